// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with internal baud timing and valid/ready input
module uart_tx_param #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);
  localparam int BW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $fatal(1, "uart_tx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state, w_state;
  logic [BW-1:0]        r_baud, w_baud;
  logic [3:0]           r_bit, w_bit;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_par, w_par;
  logic                 r_tx, w_tx;
  logic                 r_done, w_done;
  logic                 w_last;

  assign w_last   = r_baud == BAUD_LAST;
  assign tx_ready = r_state == S_IDLE;
  assign tx_busy  = !tx_ready;
  assign tx_done  = r_done;
  assign tx       = r_tx;

  // state and datapath registers; tx is registered so every bit level lasts whole baud periods
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_tx    <= w_tx;
      r_done  <= w_done;
    end
  end

  // next state: each transition loads the level of the following bit into tx at the bit boundary
  always_comb begin
    w_state = r_state;
    w_baud  = w_last ? '0 : r_baud + BW'(1);
    w_bit   = r_bit;
    w_shift = r_shift;
    w_par   = r_par;
    w_tx    = r_tx;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud = '0;
        if (tx_valid) begin
          w_state = S_START;
          w_shift = tx_data;
          w_par   = (^tx_data) ^ (PARITY == 1);
          w_tx    = 1'b0;
        end
      end
      S_START: if (w_last) begin
        w_state = S_DATA;
        w_tx    = r_shift[0];
        w_bit   = '0;
      end
      S_DATA: if (w_last) begin
        w_shift = r_shift >> 1;
        w_tx    = r_shift[1];
        w_bit   = r_bit + 4'd1;
        if (r_bit == DATA_LAST) begin
          w_state = (PARITY != 0) ? S_PARITY : S_STOP;
          w_tx    = (PARITY != 0) ? r_par : 1'b1;
          w_bit   = '0;
        end
      end
      S_PARITY: if (w_last) begin
        w_state = S_STOP;
        w_tx    = 1'b1;
      end
      S_STOP: if (w_last) begin
        w_bit = r_bit + 4'd1;
        if (r_bit == STOP_LAST) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_bit   = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations driven by one stimulus table and checked against a frame-level model
module tb_uart_tx_param;
  localparam int NC = 2000;
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int STP [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_w [4];
  logic       rdy_w [4];
  logic       bsy_w [4];
  logic       dn_w [4];

  logic       sv [NC];
  logic       sr [NC];
  logic [7:0] sd [NC];
  logic [3:0] obs [4][NC];
  int         n = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(PAR[g]), .STOP_BITS(STP[g])) u_dut (
      .sclk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(rdy_w[g]), .tx_busy(bsy_w[g]), .tx_done(dn_w[g]), .tx(tx_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic [7:0] d, input logic r, input int k);
    repeat (k) begin
      sv[n] = v;
      sd[n] = d;
      sr[n] = r;
      n++;
    end
  endtask

  // line levels of one frame, in transmission order: start, data LSB first, optional parity, stops
  function automatic logic [15:0] frame(input int g, input logic [7:0] dd, output int len);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = dd;
    if (PAR[g] != 0) b[9] = (PAR[g] == 2) ? ^dd : ~^dd;
    len = 9 + int'(PAR[g] != 0) + STP[g];
    return b;
  endfunction

  initial begin
    put(0, 8'h00, 0, 50);
    put(1, 8'hA5, 0, 1);  put(0, 8'h00, 0, 60);
    put(1, 8'h07, 0, 1);  put(0, 8'h00, 0, 60);
    put(1, 8'h3C, 0, 1);  put(0, 8'h00, 0, 60);
    put(1, 8'h00, 0, 41); put(1, 8'hFF, 0, 9); put(1, 8'h55, 0, 11); put(0, 8'h55, 0, 60);
    put(1, 8'hA5, 0, 1);  put(0, 8'h00, 0, 17); put(0, 8'h00, 1, 3); put(0, 8'h00, 0, 5);
    put(1, 8'h81, 0, 1);  put(0, 8'h00, 0, 60);
    repeat (25) begin
      put(1, 8'($urandom), 0, $urandom_range(1, 3));
      put(0, 8'($urandom), 0, $urandom_range(0, 50));
    end
    put(0, 8'h00, 0, 60);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 4; g++)
      chk($sformatf("reset dut%0d {tx,rdy,bsy,done}", g), {tx_w[g], rdy_w[g], bsy_w[g], dn_w[g]}, 4'b1100);
    rst_n = 1'b1;

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) obs[g][c] = {tx_w[g], rdy_w[g], bsy_w[g], dn_w[g]};
      tx_valid = sv[c];
      tx_data  = sd[c];
      rst_n    = !sr[c];
      if (c > 0 && sr[c] && !sr[c-1]) begin
        #1;
        for (int g = 0; g < 4; g++)
          chk($sformatf("async_rst dut%0d {tx,done}", g), {tx_w[g], dn_w[g]}, 2'b10);
      end
    end

    for (int g = 0; g < 4; g++) begin
      logic        have, rs, inf, dn, etx;
      int          st, len;
      logic [15:0] fb;
      have = 1'b0;
      st = 0;
      len = 0;
      fb = '1;
      for (int c = 0; c < n; c++) begin
        rs = c > 0 && sr[c-1];
        if (rs) have = 1'b0;
        inf = have && c > st && c <= st + 4 * len;
        dn  = have && c == st + 4 * len + 1;
        etx = inf ? fb[(c - st - 1) / 4] : 1'b1;
        chk($sformatf("dut%0d cyc%0d {tx,rdy,bsy,done}", g, c), obs[g][c], {etx, !inf, inf, dn});
        if (!inf && sv[c] && !sr[c]) begin
          have = 1'b1;
          st = c;
          fb = frame(g, sd[c], len);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
